// File: rtl/dvp_emu_pkg.sv
// Shared types and constants for the DVP camera emulator: FSM states, test
// pattern encodings and the RGB565 colour-bar table.
package dvp_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  typedef enum logic [1:0] {
    PAT_RAMP,
    PAT_BARS,
    PAT_LINE,
    PAT_ZERO
  } pattern_t;

  localparam logic [15:0] COLOR_BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic int line_tp(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern byte generator; the parent registers the result
// so no combinational path reaches a top-level output.
module dvp_pattern_gen
  import dvp_emu_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int XW       = 10
) (
  input  pattern_t         pattern_i,
  input  logic [XW-1:0]    x_i,
  input  logic             phase_i,
  input  logic [7:0]       line_i,
  output logic [7:0]       data_o
);

  logic [XW:0]  hpos;
  logic [2:0]   bar;
  logic [15:0]  color;

  // Byte ramp is the raw horizontal counter; phase 0 selects the high byte.
  always_comb begin
    hpos   = {x_i, phase_i};
    bar    = 3'(int'(x_i) / (H_ACTIVE / 8));
    color  = COLOR_BARS[bar];
    data_o = 8'h00;
    case (pattern_i)
      PAT_RAMP: data_o = 8'(hpos);
      PAT_BARS: data_o = phase_i ? color[7:0] : color[15:8];
      PAT_LINE: data_o = line_i;
      default:  data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/dvp_cam_emulator.sv
// OV7670-style DVP source: divided pixel clock plus vsync/href/data framing,
// all advanced on the pclk falling edge so a receiver samples on the rise.
module dvp_cam_emulator
  import dvp_emu_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_HALF   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  data_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  localparam int LINE_TP = line_tp(H_ACTIVE, H_BLANK);
  localparam int HW      = $clog2(LINE_TP);
  localparam int V_MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int DW      = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam int XW      = $clog2(H_ACTIVE);

  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  state_t        state_q, state_d;
  pattern_t      pattern_q, pattern_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          div_wrap;
  logic          fall;
  logic          line_end;
  logic          last_line;
  int            lines;
  logic [XW-1:0] pg_x;
  logic [7:0]    pg_line;
  logic [7:0]    pat_byte;

  // Pixel-clock divider and frame position; everything but the divider
  // moves only on a fall event.
  always_comb begin
    div_wrap     = (div_q == DW'(PCLK_HALF - 1));
    div_d        = div_wrap ? '0 : div_q + DW'(1);
    pclk_d       = div_wrap ? ~pclk_q : pclk_q;
    fall         = div_wrap & pclk_q;
    line_end     = (hcnt_q == HW'(LINE_TP - 1));
    case (state_q)
      VSYNC:   lines = VSYNC_LINES;
      VBACK:   lines = V_BACK;
      ACTIVE:  lines = V_ACTIVE;
      default: lines = V_FRONT;
    endcase
    last_line    = (vcnt_q == VW'(lines - 1));
    state_d      = state_q;
    pattern_d    = pattern_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (fall) begin
      if (state_q == IDLE) begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable_i) begin
          state_d   = VSYNC;
          pattern_d = pattern_t'(pattern_sel_i);
        end
      end else begin
        hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
        if (line_end) begin
          vcnt_d = last_line ? '0 : vcnt_q + VW'(1);
          if (last_line) begin
            case (state_q)
              VSYNC:  state_d = VBACK;
              VBACK:  state_d = ACTIVE;
              ACTIVE: state_d = VFRONT;
              default: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = (frame_cnt_q == 16'hFFFF) ? 16'h0000 : frame_cnt_q + 16'd1;
                if (enable_i) begin
                  state_d   = VSYNC;
                  pattern_d = pattern_t'(pattern_sel_i);
                end else begin
                  state_d = IDLE;
                end
              end
            endcase
          end
        end
      end
    end
  end

  // Outputs are decoded from the next position so they register together
  // with the state on the pclk falling edge.
  always_comb begin
    pg_x    = XW'(hcnt_d >> 1);
    pg_line = 8'(vcnt_d);
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (fall) begin
      vsync_d = (state_d == VSYNC);
      href_d  = (state_d == ACTIVE) && (hcnt_d < HW'(2 * H_ACTIVE));
      data_d  = href_d ? pat_byte : 8'h00;
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern_gen (
    .pattern_i (pattern_d),
    .x_i       (pg_x),
    .phase_i   (hcnt_d[0]),
    .line_i    (pg_line),
    .data_o    (pat_byte)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q        <= '0;
      pclk_q       <= 1'b0;
      state_q      <= IDLE;
      pattern_q    <= PAT_RAMP;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      div_q        <= div_d;
      pclk_q       <= pclk_d;
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pclk_o       = pclk_q;
  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign data_o       = data_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_cam_emulator.sv
// Scoreboard bench for dvp_cam_emulator: stimulus pushes expected frame bytes
// and frame counts, monitors on pclk and clk pop and compare.
module tb_dvp_cam_emulator;

   localparam int H_ACTIVE    = 8;
   localparam int H_BLANK     = 4;
   localparam int V_ACTIVE    = 3;
   localparam int VSYNC_LINES = 1;
   localparam int V_BACK      = 1;
   localparam int V_FRONT     = 1;
   localparam int PCLK_HALF   = 2;
   localparam int LINE_TP     = 2 * H_ACTIVE + H_BLANK;
   localparam int FRAME_CLK   = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE_TP * 2 * PCLK_HALF;
   localparam int WAIT_LIMIT  = 2 * FRAME_CLK + 100;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic        pclk;
   logic        vsync;
   logic        href;
   logic [7:0]  data;
   logic        frame_done;
   logic [15:0] frame_cnt;

   int errors = 0;
   int checks = 0;
   logic [7:0]  expBytes[$];
   logic [15:0] expCnt[$];
   int rstEpoch = 0;
   int framesStarted = 0;
   bit abortRun = 0;

   dvp_cam_emulator #(
      .H_ACTIVE    (H_ACTIVE),
      .H_BLANK     (H_BLANK),
      .V_ACTIVE    (V_ACTIVE),
      .VSYNC_LINES (VSYNC_LINES),
      .V_BACK      (V_BACK),
      .V_FRONT     (V_FRONT),
      .PCLK_HALF   (PCLK_HALF)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .pattern_sel_i (pattern_sel),
      .pclk_o        (pclk),
      .vsync_o       (vsync),
      .href_o        (href),
      .data_o        (data),
      .frame_done_o  (frame_done),
      .frame_cnt_o   (frame_cnt)
   );

   // Free-running system clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic flagFailure(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   // Reference pattern: byte h of the given active line, straight from the pattern rules.
   function automatic logic [7:0] modelByte(input int pat, input int line, input int h);
      logic [15:0] bars [8];
      logic [15:0] c;
      int x;
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      x = h / 2;
      case (pat)
         0: return 8'(h % 256);
         1: begin
            c = bars[x / (H_ACTIVE / 8)];
            return (h % 2 == 0) ? c[15:8] : c[7:0];
         end
         2: return 8'(line % 256);
         default: return 8'h00;
      endcase
   endfunction

   task automatic waitFor(input int sel, input logic level, input int maxCycles, input string what, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         case (sel)
            0: ok = (vsync === level);
            1: ok = (href === level);
            default: ok = (frame_done === level);
         endcase
         if (ok) break;
      end
      if (!ok) flagFailure({"timeout waiting for ", what});
   endtask

   task automatic startFrame(output bit ok);
      logic [1:0] framePat;
      waitFor(0, 1'b1, WAIT_LIMIT, "vsync start", ok);
      if (!ok) begin
         abortRun = 1'b1;
         return;
      end
      framePat = pattern_sel;
      framesStarted++;
      expCnt.push_back(16'(framesStarted));
      for (int l = 0; l < V_ACTIVE; l++)
         for (int h = 0; h < 2 * H_ACTIVE; h++)
            expBytes.push_back(modelByte(int'(framePat), l, h));
   endtask

   // One frame: glitch the pattern mid-ACTIVE, program the next frame's
   // pattern, optionally drop enable, then wait for the end of the frame.
   task automatic applyStimulus(input logic [1:0] nextPat, input bit dropEnable);
      bit ok;
      int activity;
      if (abortRun) return;
      startFrame(ok);
      if (!ok) return;
      waitFor(1, 1'b1, WAIT_LIMIT, "href line 0", ok);
      if (!ok) begin abortRun = 1'b1; return; end
      pattern_sel = 2'($urandom_range(0, 3));
      waitFor(1, 1'b0, WAIT_LIMIT, "href low", ok);
      if (!ok) begin abortRun = 1'b1; return; end
      waitFor(1, 1'b1, WAIT_LIMIT, "href line 1", ok);
      if (!ok) begin abortRun = 1'b1; return; end
      pattern_sel = nextPat;
      if (dropEnable) enable = 1'b0;
      waitFor(2, 1'b1, WAIT_LIMIT, "frame_done", ok);
      if (!ok) begin abortRun = 1'b1; return; end
      if (dropEnable) begin
         activity = 0;
         repeat (3 * LINE_TP * 2 * PCLK_HALF) begin
            @(negedge clk);
            if (vsync !== 1'b0 || href !== 1'b0 || frame_done !== 1'b0) activity++;
         end
         checkOutput("idle after disable", activity, 0);
      end
   endtask

   // pclk-domain monitor: samples like a receiver on the pclk rising edge.
   initial begin
      int ep;
      logic pvs, phr, vsFall;
      int vsRun, hrRun, lowRun;
      bit firstLine;
      ep = 0; pvs = 0; phr = 0; vsRun = 0; hrRun = 0; lowRun = 0; firstLine = 0;
      forever begin
         @(posedge pclk);
         #1;
         if (ep != rstEpoch) begin
            ep = rstEpoch; pvs = 0; phr = 0; vsRun = 0; hrRun = 0; lowRun = 0; firstLine = 0;
         end
         if (href === 1'b1) begin
            if (expBytes.size() == 0) flagFailure("unexpected href byte");
            else checkOutput("pixel byte", data, expBytes.pop_front());
         end else begin
            checkOutput("blank data", data, 0);
         end
         vsFall = pvs && !vsync;
         if (vsync) vsRun++;
         if (vsFall) begin
            checkOutput("vsync width", vsRun, VSYNC_LINES * LINE_TP);
            vsRun = 0;
            firstLine = 1;
         end
         if (href && !phr) begin
            if (firstLine) begin
               checkOutput("vback gap", lowRun, V_BACK * LINE_TP);
               firstLine = 0;
            end else begin
               checkOutput("hblank gap", lowRun, H_BLANK);
            end
            hrRun = 1;
         end else if (href) begin
            hrRun++;
         end
         if (!href && phr) checkOutput("href width", hrRun, 2 * H_ACTIVE);
         if (vsFall || (!href && phr)) lowRun = 1;
         else if (!href) lowRun++;
         pvs = vsync;
         phr = href;
      end
   end

   // clk-domain monitor: frame_done pulse, frame count and frame length.
   initial begin
      logic pvs, pfd;
      int cyc, startCyc;
      bit haveStart;
      pvs = 0; pfd = 0; cyc = 0; startCyc = 0; haveStart = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            pvs = 0; pfd = 0; haveStart = 0;
         end else begin
            if (frame_done) begin
               checkOutput("frame_done width", pfd, 0);
               if (expCnt.size() == 0) flagFailure("unexpected frame_done");
               else checkOutput("frame count", frame_cnt, expCnt.pop_front());
               if (haveStart) checkOutput("frame length clk", cyc - startCyc, FRAME_CLK);
            end
            if (vsync && !pvs) begin
               startCyc = cyc;
               haveStart = 1;
            end
            pvs = vsync;
            pfd = frame_done;
         end
      end
   end

   // Watchdog: end the run with a failure if the sequence hangs.
   initial begin
      #1_000_000;
      flagFailure("watchdog expired");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Main sequence: reset and idle checks, directed and random frames,
   // then an asynchronous reset in the middle of an active line.
   initial begin
      bit ok;
      logic prevPclk;
      int rise1, rise2, nRise, activity;

      rst = 1'b1;
      enable = 1'b0;
      pattern_sel = 2'd0;
      repeat (5) @(negedge clk);
      checkOutput("reset pclk", pclk, 0);
      checkOutput("reset vsync", vsync, 0);
      checkOutput("reset href", href, 0);
      checkOutput("reset data", data, 0);
      checkOutput("reset frame_cnt", frame_cnt, 0);
      rst = 1'b0;

      prevPclk = pclk; rise1 = -100; rise2 = 0; nRise = 0; activity = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pclk && !prevPclk) begin
            if (nRise == 0) rise1 = i;
            else if (nRise == 1) rise2 = i;
            nRise++;
         end
         prevPclk = pclk;
         if (vsync !== 1'b0 || href !== 1'b0 || data !== 8'h00 || frame_done !== 1'b0 || frame_cnt !== 16'h0000)
            activity++;
      end
      checkOutput("pclk period clk", rise2 - rise1, 2 * PCLK_HALF);
      checkOutput("idle outputs", activity, 0);

      $display("[TB] directed frames");
      enable = 1'b1;
      applyStimulus(2'd2, 1'b0);
      applyStimulus(2'd1, 1'b0);
      applyStimulus(2'd3, 1'b1);
      enable = 1'b1;

      $display("[TB] random frames");
      for (int f = 0; f < 4; f++) begin
         bit drop;
         drop = ($urandom_range(0, 3) == 0);
         applyStimulus(2'($urandom_range(0, 3)), drop);
         enable = 1'b1;
      end

      $display("[TB] reset mid-line");
      if (!abortRun) begin
         startFrame(ok);
         if (ok) waitFor(1, 1'b1, WAIT_LIMIT, "href before reset", ok);
         if (ok) begin
            #2;
            rst = 1'b1;
            #1;
            checkOutput("async reset href", href, 0);
            checkOutput("async reset vsync", vsync, 0);
            checkOutput("async reset data", data, 0);
            checkOutput("async reset pclk", pclk, 0);
            checkOutput("async reset frame_cnt", frame_cnt, 0);
            repeat (3) @(negedge clk);
            expBytes.delete();
            expCnt.delete();
            framesStarted = 0;
            rstEpoch++;
            pattern_sel = 2'd1;
            rst = 1'b0;
            waitFor(0, 1'b1, 4 * PCLK_HALF, "vsync after reset", ok);
            applyStimulus(2'd2, 1'b0);
            applyStimulus(2'd0, 1'b1);
         end else begin
            abortRun = 1'b1;
         end
      end

      checkOutput("bytes left", expBytes.size(), 0);
      checkOutput("frames left", expCnt.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
